// File: rtl/riscv_zero_imem.sv
// +----------------------------------------------------------------------------+
// | riscv_zero_imem: latency-configurable instruction memory with program port |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module riscv_zero_imem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [63:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_data,
  output logic                           rsp_err,
  input  logic                           flush,
  input  logic                           prog_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr,
  input  logic [31:0]                    prog_data
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT     = 4'(LATENCY);
  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic          fetch_err;
  logic [31:0]   rd_word;

  assign word_idx  = addr_q[AW+1:2];
  // Power-of-two depth: out of range is any set bit above the index field.
  assign fetch_err = (|addr_q[1:0]) | (|addr_q[63:AW+2]);
  assign rd_word   = mem_q[word_idx];

  assign req_ready = (state_q == ST_IDLE) && !flush;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // WAIT always holds for LATENCY+1 edges: the first covers the captured
  // address reaching the array, the counter covers the configured wait.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          cnt_d   = LAT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          rsp_data_d = fetch_err ? NOP_INS : rd_word;
          rsp_err_d  = fetch_err;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (flush || rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 64'd0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Program contents survive reset; the read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

endmodule

`default_nettype wire
